// File: rtl/pipe_trig_pkg.sv
// pipe_trig_pkg: shared FSM state type and sizing helpers for pipe_trigger_monitor.
package pipe_trig_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIGGERED = 2'd2} state_t;
  function automatic int run_cnt_w(input int thresh);
    return $clog2(thresh + 1);
  endfunction
  function automatic longint unsigned sat_lim(input int w);
    return (longint'(1) << w) - 1;
  endfunction
endpackage

// File: rtl/pipe_trig_stage.sv
// pipe_trig_stage: one valid-tagged WIDTH-bit pipeline register with sync reset.
module pipe_trig_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);
  always_ff @(posedge clk)
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
endmodule

// File: rtl/pipe_trigger_monitor.sv
// pipe_trigger_monitor: DEPTH-stage tagged pipeline, masked last-stage compare, armed run counter with sticky trigger.
// Optional PIPE_TRIG_SNAP_EN adds a pipeline snapshot captured on entry to TRIGGERED.
module pipe_trigger_monitor
  import pipe_trig_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int THRESH = 3,
  parameter int CNT_W  = 8
) (
  input  logic             I1294_clk,
  input  logic             I1301_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic             arm,
  input  logic             clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             match,
  output logic             trig,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       state
`ifdef PIPE_TRIG_SNAP_EN
  ,
  output logic [WIDTH*DEPTH-1:0] trig_snap,
  output logic                   trig_snap_vld
`endif
);
  localparam int RW = run_cnt_w(THRESH);
  localparam logic [CNT_W-1:0] HIT_MAX = CNT_W'(sat_lim(CNT_W));
  logic [WIDTH-1:0] d_chain [DEPTH+1];
  logic [DEPTH:0]   v_chain;
  logic [RW-1:0]    run_cnt, run_nx;
  logic [CNT_W-1:0] hit_nx;
  logic             beat_hit, enter_trig;
  state_t           st;
  assign d_chain[0] = in_data;
  assign v_chain[0] = in_valid;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_trig_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (I1294_clk),
      .rst    (I1301_rst),
      .d_valid(v_chain[i]),
      .d_data (d_chain[i]),
      .q_valid(v_chain[i+1]),
      .q_data (d_chain[i+1])
    );
  end
  assign out_data   = d_chain[DEPTH];
  assign out_valid  = v_chain[DEPTH];
  assign state      = st;
  assign beat_hit   = v_chain[DEPTH] && (((d_chain[DEPTH] ^ pattern) & mask) == '0);
  assign run_nx     = run_cnt + RW'(1);
  assign hit_nx     = (hit_cnt == HIT_MAX) ? hit_cnt : hit_cnt + CNT_W'(1);
  assign enter_trig = !clr && st == ARMED && beat_hit && run_nx == RW'(THRESH);
  always_ff @(posedge I1294_clk)
    if (I1301_rst) begin
      st      <= IDLE;
      run_cnt <= '0;
      hit_cnt <= '0;
      match   <= 1'b0;
      trig    <= 1'b0;
    end else begin
      match <= beat_hit;
      if (clr) begin
        st      <= IDLE;
        run_cnt <= '0;
        hit_cnt <= '0;
        trig    <= 1'b0;
      end else
        case (st)
          IDLE: if (arm) begin
            st      <= ARMED;
            run_cnt <= '0;
          end
          ARMED: if (beat_hit) begin
            hit_cnt <= hit_nx;
            run_cnt <= run_nx;
            if (enter_trig) begin
              st   <= TRIGGERED;
              trig <= 1'b1;
            end
          end else if (v_chain[DEPTH]) run_cnt <= '0;
          TRIGGERED: if (beat_hit) hit_cnt <= hit_nx;
          default: st <= IDLE;
        endcase
    end
`ifdef PIPE_TRIG_SNAP_EN
  logic [WIDTH*DEPTH-1:0] flat;
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign flat[i*WIDTH +: WIDTH] = d_chain[i+1];
  end
  assign trig_snap_vld = trig;
  // Snapshot shows the stages as they stood when the triggering beat was compared.
  always_ff @(posedge I1294_clk)
    if (I1301_rst || clr) trig_snap <= '0;
    else if (enter_trig) trig_snap <= flat;
`endif
endmodule

// File: tb/tb_pipe_trigger_monitor.sv
// tb_pipe_trigger_monitor: directed self-checking bench for pipe_trigger_monitor (optionally with PIPE_TRIG_SNAP_EN).
module tb_pipe_trigger_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] pattern = '0;
  logic [7:0] mask = '0;
  logic       arm = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] out_data, s_out_data;
  logic       out_valid, match, trig, s_out_valid, s_match, s_trig;
  logic [7:0] hit_cnt;
  logic [2:0] s_hit_cnt;
  logic [1:0] state, s_state;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pipe_trigger_monitor dut (
    .I1294_clk(clk), .I1301_rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pattern(pattern), .mask(mask), .arm(arm), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .match(match), .trig(trig),
    .hit_cnt(hit_cnt), .state(state)
`ifdef PIPE_TRIG_SNAP_EN
    , .trig_snap(), .trig_snap_vld()
`endif
  );
  pipe_trigger_monitor #(.CNT_W(3)) dut_s (
    .I1294_clk(clk), .I1301_rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pattern(pattern), .mask(mask), .arm(arm), .clr(clr),
    .out_data(s_out_data), .out_valid(s_out_valid), .match(s_match), .trig(s_trig),
    .hit_cnt(s_hit_cnt), .state(s_state)
`ifdef PIPE_TRIG_SNAP_EN
    , .trig_snap(), .trig_snap_vld()
`endif
  );
`ifdef PIPE_TRIG_SNAP_EN
  logic [7:0]  p_out_data, p_hit_cnt;
  logic        p_out_valid, p_match, p_trig, p_snap_vld;
  logic [1:0]  p_state;
  logic [15:0] p_snap;
  pipe_trigger_monitor #(.DEPTH(2), .THRESH(2)) dut_p (
    .I1294_clk(clk), .I1301_rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pattern(pattern), .mask(mask), .arm(arm), .clr(clr),
    .out_data(p_out_data), .out_valid(p_out_valid), .match(p_match), .trig(p_trig),
    .hit_cnt(p_hit_cnt), .state(p_state), .trig_snap(p_snap), .trig_snap_vld(p_snap_vld)
  );
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; arm = 1'b0; clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, trig, match, state, hit_cnt, out_data} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state: got v=%b t=%b m=%b st=%0d hit=%0d d=%h want all 0", out_valid, trig, match, state, hit_cnt, out_data);
    end
    for (int c = 0; c < 20; c++) begin
      beat(1'b0, 8'h00);
      tests++;
      if ({out_valid, trig, state, hit_cnt} !== 12'd0) begin
        fails++;
        $display("FAIL idle_cycle%0d: got v=%b t=%b st=%0d hit=%0d want 0", c, out_valid, trig, state, hit_cnt);
      end
    end
  endtask
  task automatic test_latency();
    do_reset();
    pattern = 8'hA5; mask = 8'hFF;
    beat(1'b1, 8'hA5);
    for (int e = 2; e <= 6; e++) begin
      beat(1'b0, 8'h00);
      if (e == 3) begin
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_early_valid: got %b want 0", out_valid); end
      end
      if (e == 4) begin
        tests++;
        if ({out_valid, out_data, match} !== {1'b1, 8'hA5, 1'b0}) begin
          fails++;
          $display("FAIL lat_out: got v=%b d=%h m=%b want v=1 d=a5 m=0", out_valid, out_data, match);
        end
      end
      if (e == 5) begin
        tests++;
        if ({match, state, hit_cnt} !== {1'b1, 2'd0, 8'd0}) begin
          fails++;
          $display("FAIL lat_match: got m=%b st=%0d hit=%0d want m=1 st=0 hit=0", match, state, hit_cnt);
        end
      end
      if (e == 6) begin
        tests++;
        if ({match, out_valid} !== 2'b00) begin fails++; $display("FAIL lat_after: got m=%b v=%b want 0 0", match, out_valid); end
      end
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    pattern = 8'hA5; mask = 8'hFF;
    for (int c = 0; c < 3; c++) beat(1'b1, 8'hA5);
    rst = 1'b1;
    beat(1'b0, 8'h00);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      beat(1'b0, 8'h00);
      tests++;
      if ({out_valid, match, out_data} !== 10'd0) begin
        fails++;
        $display("FAIL mid_reset%0d: got v=%b m=%b d=%h want 0", c, out_valid, match, out_data);
      end
    end
  endtask
  task automatic test_threshold();
    logic [7:0] seq [6] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5};
    do_reset();
    pattern = 8'hA5; mask = 8'hFF;
    do_arm();
    tests++;
    if (state !== 2'd1) begin fails++; $display("FAIL arm_state: got %0d want 1", state); end
    foreach (seq[k]) beat(1'b1, seq[k]);
    for (int c = 0; c < 3; c++) beat(1'b0, 8'h00);
    tests++;
    if ({trig, state, hit_cnt} !== {1'b0, 2'd1, 8'd4}) begin
      fails++;
      $display("FAIL thr_pre: got t=%b st=%0d hit=%0d want t=0 st=1 hit=4", trig, state, hit_cnt);
    end
    beat(1'b0, 8'h00);
    tests++;
    if ({trig, state, hit_cnt, match} !== {1'b1, 2'd2, 8'd5, 1'b1}) begin
      fails++;
      $display("FAIL thr_trig: got t=%b st=%0d hit=%0d m=%b want t=1 st=2 hit=5 m=1", trig, state, hit_cnt, match);
    end
    do_arm();
    tests++;
    if ({trig, state} !== {1'b1, 2'd2}) begin fails++; $display("FAIL trig_arm_ignored: got t=%b st=%0d want t=1 st=2", trig, state); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if ({trig, state, hit_cnt} !== 11'd0) begin
      fails++;
      $display("FAIL clr_trig: got t=%b st=%0d hit=%0d want 0", trig, state, hit_cnt);
    end
  endtask
  task automatic test_mask_bubbles();
    logic       vs [13] = '{1, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    logic [7:0] ds [13] = '{8'h35, 8'h00, 8'hF5, 8'h34, 8'h35, 8'h00, 8'hF5, 8'h00, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    pattern = 8'h05; mask = 8'h0F;
    do_arm();
    for (int e = 1; e <= 13; e++) begin
      beat(vs[e-1], ds[e-1]);
      if (e == 5) begin
        tests++;
        if ({match, hit_cnt} !== {1'b1, 8'd1}) begin fails++; $display("FAIL mask_35: got m=%b hit=%0d want m=1 hit=1", match, hit_cnt); end
      end
      if (e == 7) begin
        tests++;
        if ({match, hit_cnt} !== {1'b1, 8'd2}) begin fails++; $display("FAIL mask_f5: got m=%b hit=%0d want m=1 hit=2", match, hit_cnt); end
      end
      if (e == 8) begin
        tests++;
        if ({match, trig, hit_cnt} !== {1'b0, 1'b0, 8'd2}) begin fails++; $display("FAIL mask_34: got m=%b t=%b hit=%0d want m=0 t=0 hit=2", match, trig, hit_cnt); end
      end
      if (e == 12) begin
        tests++;
        if ({trig, hit_cnt} !== {1'b0, 8'd4}) begin fails++; $display("FAIL bubble_pre: got t=%b hit=%0d want t=0 hit=4", trig, hit_cnt); end
      end
      if (e == 13) begin
        tests++;
        if ({trig, state, hit_cnt} !== {1'b1, 2'd2, 8'd5}) begin fails++; $display("FAIL bubble_trig: got t=%b st=%0d hit=%0d want t=1 st=2 hit=5", trig, state, hit_cnt); end
      end
    end
  endtask
  task automatic test_arm_hold();
    do_reset();
    pattern = 8'hA5; mask = 8'hFF;
    do_arm();
    for (int e = 1; e <= 7; e++) begin
      arm = (e == 6);
      beat(e <= 3, 8'hA5);
      if (e == 6) begin
        tests++;
        if ({trig, state} !== {1'b0, 2'd1}) begin fails++; $display("FAIL arm_hold_pre: got t=%b st=%0d want t=0 st=1", trig, state); end
      end
      if (e == 7) begin
        tests++;
        if ({trig, hit_cnt} !== {1'b1, 8'd3}) begin fails++; $display("FAIL arm_hold_trig: got t=%b hit=%0d want t=1 hit=3", trig, hit_cnt); end
      end
    end
    arm = 1'b0;
  endtask
  task automatic test_sat_clr();
    do_reset();
    pattern = 8'hA5; mask = 8'hFF;
    do_arm();
    for (int c = 0; c < 10; c++) beat(1'b1, 8'hA5);
    for (int c = 0; c < 4; c++) beat(1'b0, 8'h00);
    tests++;
    if ({s_hit_cnt, s_trig, hit_cnt} !== {3'd7, 1'b1, 8'd10}) begin
      fails++;
      $display("FAIL saturate: got s_hit=%0d s_t=%b hit=%0d want 7 1 10", s_hit_cnt, s_trig, hit_cnt);
    end
    arm = 1'b1; clr = 1'b1;
    tick();
    arm = 1'b0; clr = 1'b0;
    tests++;
    if ({state, hit_cnt, trig, s_state, s_hit_cnt} !== 16'd0) begin
      fails++;
      $display("FAIL arm_clr: got st=%0d hit=%0d t=%b s_st=%0d s_hit=%0d want 0", state, hit_cnt, trig, s_state, s_hit_cnt);
    end
    do_arm();
    beat(1'b1, 8'hA5);
    for (int e = 2; e <= 4; e++) beat(1'b0, 8'h00);
    clr = 1'b1;
    beat(1'b0, 8'h00);
    clr = 1'b0;
    tests++;
    if ({state, hit_cnt} !== 10'd0) begin fails++; $display("FAIL clr_discard: got st=%0d hit=%0d want 0 0", state, hit_cnt); end
  endtask
`ifdef PIPE_TRIG_SNAP_EN
  task automatic test_snap();
    do_reset();
    pattern = 8'h00; mask = 8'h00;
    do_arm();
    beat(1'b1, 8'h11);
    beat(1'b1, 8'h22);
    beat(1'b1, 8'h11);
    beat(1'b0, 8'h00);
    tests++;
    if ({p_trig, p_snap_vld, p_snap} !== {2'b11, 16'h2211}) begin
      fails++;
      $display("FAIL snap_cap: got t=%b sv=%b snap=%h want 1 1 2211", p_trig, p_snap_vld, p_snap);
    end
    for (int c = 0; c < 3; c++) beat(1'b1, 8'h77);
    tests++;
    if ({p_snap_vld, p_snap} !== {1'b1, 16'h2211}) begin fails++; $display("FAIL snap_hold: got sv=%b snap=%h want 1 2211", p_snap_vld, p_snap); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if ({p_snap_vld, p_snap} !== 17'd0) begin fails++; $display("FAIL snap_clr: got sv=%b snap=%h want 0 0", p_snap_vld, p_snap); end
  endtask
`endif
  initial begin
    test_reset();
    test_latency();
    test_mid_reset();
    test_threshold();
    test_mask_bubbles();
    test_arm_hold();
    test_sat_clr();
`ifdef PIPE_TRIG_SNAP_EN
    test_snap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_trigger_monitor.md
# pipe_trigger_monitor

Parametrised successor to the fixed-depth flop-chain trigger subcircuits in the trojan-detection benchmark set. Carries a WIDTH-bit sample stream through a DEPTH-stage valid-tagged pipeline and compares the final stage against a masked pattern. An armed FSM counts consecutive matches and raises a sticky trigger after THRESH in a row. Sits beside the benchmark netlists as a reusable, configurable trigger/monitor for trojan-insertion and detection experiments.

## Interface
- WIDTH, 8: data/pattern/mask width in bits; legal range ≥1.
- DEPTH, 4: pipeline stages; legal range ≥1.
- THRESH, 3: consecutive matches needed to trigger; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the total-hit counter.
- I1294_clk  in  1  single clock; all state updates on the rising edge.
- I1301_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  sample.
- pattern  in  WIDTH  compare value; sampled every cycle, never latched.
- mask  in  WIDTH  1 = bit compared, 0 = don't-care.
- arm  in  1  pulse; leaves IDLE.
- clr  in  1  pulse; return to IDLE and clear counters.
- out_data  out  WIDTH  last pipeline stage (stage DEPTH-1).
- out_valid  out  1  valid tag of the last stage.
- match  out  1  registered: the last-stage beat matched.
- trig  out  1  sticky trigger; high exactly in TRIGGERED.
- hit_cnt  out  CNT_W  saturating count of matching beats while armed.
- state  out  2  FSM state encoding: IDLE=0, ARMED=1, TRIGGERED=2.

## Operation
- Pipeline advances every cycle:
  - stage[0] <= in_data; v[0] <= in_valid.
  - stage[k] <= stage[k-1]; v[k] <= v[k-1].
- Beat match (combinational): v[DEPTH-1] && ((stage[DEPTH-1] ^ pattern) & mask) == 0.
  - mask == 0 matches every valid beat.
  - Invalid beats never match.
- match <= beat match, in every state.
- FSM; clr has priority over everything:
  - IDLE: arm → ARMED with run_cnt = 0.
  - ARMED, matching beat: run_cnt++. If run_cnt+1 == THRESH → TRIGGERED.
  - ARMED, valid non-matching beat: run_cnt = 0.
  - ARMED, invalid beat: run_cnt holds.
  - TRIGGERED: holds until clr; arm is ignored.
  - clr, any state: → IDLE; run_cnt = 0; hit_cnt = 0.
  - arm in ARMED: no effect; run_cnt is not cleared.
- run_cnt is $clog2(THRESH+1) bits and never exceeds THRESH.
- hit_cnt increments on a matching beat in ARMED or TRIGGERED. Saturates at 2^CNT_W-1 with no wrap.
- Reset: all stages = 0, all v = 0, out_valid = 0, out_data = 0, match = 0, trig = 0, hit_cnt = 0, run_cnt = 0, state = IDLE.
- Reset mid-operation discards all in-flight beats.

## Timing
- A beat sampled at edge 0 is in stage[DEPTH-1] after edge DEPTH-1.
  - out_data/out_valid: latency DEPTH cycles.
- match, trig and hit_cnt update at edge DEPTH. Latency DEPTH+1 from input to flag.
- trig rises on the same edge as the THRESH-th consecutive match.
- The triggering beat is counted in hit_cnt on that edge.
- clr at edge t: outputs cleared after edge t. A match on the same edge is discarded.
- arm and clr on the same edge: clr wins; state = IDLE.
- pattern/mask changes take effect on the next comparison edge.
- No backpressure; no bubbles are inserted.

## Configuration
- PIPE_TRIG_SNAP_EN defined:
  - Adds output trig_snap [WIDTH*DEPTH] and output trig_snap_vld.
  - On the edge entering TRIGGERED, captures all stages as {stage[DEPTH-1]..stage[0]}.
  - Holds the capture until clr.
  - trig_snap_vld mirrors trig.
  - Reset and clr zero both outputs.
- PIPE_TRIG_SNAP_EN undefined: neither port exists and no capture flops are built.

## Structure
- Package pipe_trig_pkg holds:
  - state_t enum (IDLE, ARMED, TRIGGERED).
  - localparam function for run_cnt width.
  - Saturation-limit helper.
- One sub-module, pipe_trig_stage: a single valid-tagged WIDTH register with synchronous reset, instantiated DEPTH times in a generate loop.
- The FSM, comparator and counters live in the top module.

## Test plan
- Reset then idle: out_valid=0, trig=0, hit_cnt=0, state=IDLE for 20 cycles with in_valid=0.
- Latency: DEPTH=4, in 0xA5 valid at cycle 0 → out_data=0xA5, out_valid=1 after edge 4, match at edge 5 with pattern=0xA5, mask=0xFF.
- Consecutive threshold, THRESH=3, armed:
  - Send match, match, non-match, match, match, match → trig rises on the 6th beat's edge.
  - hit_cnt=5 at that point.
- Mask/don't-care and bubbles:
  - mask=0x0F, pattern=0x05: beats 0x35, 0xF5 match; 0x34 fails.
  - Invalid bubbles between matches leave run_cnt unchanged.
- Saturation and clr priority:
  - CNT_W=3: 10 matches → hit_cnt=7.
  - arm and clr asserted together → state=IDLE, hit_cnt=0.
- With PIPE_TRIG_SNAP_EN, DEPTH=2: beats 0x11, 0x22 triggering at THRESH=2 → trig_snap=0x2211, held after further input until clr.
